seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexes NUM_DIGITS hex digits of the calculator result onto one shared,
//  active-low 7-segment bus plus per-digit active-low anodes.
//  Sits between the calculator core and the board display pins.
//  Owns the refresh timing, anti-ghost blanking and tear-free value updates.
//  Segment decode is done per digit by the hex_to_seg sub-module.
// PARAMETERS
//  NUM_DIGITS     4       digits scanned, 2..8
//  DIGIT_CYCLES   100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); >= 2
//  BLANK_CYCLES   2000    cycles at slot start with all anodes off; 1 <= BLANK_CYCLES < DIGIT_CYCLES
//  BLANK_LEADING  1       1 = suppress leading-zero digits (digit 0 always shown)
// PORTS
//  clk          in   1              system clock
//  rst          in   1              async active-high reset
//  en           in   1              0 = all anodes off; timing keeps running
//  load_valid   in   1              new display value offered
//  load_ready   out  1              scanner can accept a value
//  load_value   in   4*NUM_DIGITS    nibble i = digit i (digit 0 = rightmost)
//  load_dp      in   NUM_DIGITS      decimal-point enables, 1 = lit
//  an           out  NUM_DIGITS      anodes, active low, one-hot-low when driving
//  seg          out  7              segments {g,f,e,d,c,b,a}, active low
//  dp           out  1              decimal point, active low
// BEHAVIOUR
//  Reset (async): an = all 1, seg = 7'h7F, dp = 1, load_ready = 1, digit_idx = 0,
//   slot_cnt = 0, state = BLANK, shadow value/dp = 0, pending flag = 0.
//  slot_cnt counts 0..DIGIT_CYCLES-1, then wraps to 0 and digit_idx advances
//   (NUM_DIGITS-1 wraps to 0). slot_cnt width = $clog2(DIGIT_CYCLES).
//  FSM: BLANK while slot_cnt < BLANK_CYCLES; DRIVE otherwise.
//  BLANK: an = all 1. seg/dp are updated to the current digit's glyph on the
//   first cycle of BLANK, so segments settle before any anode turns on.
//  DRIVE: an[digit_idx] = 0 and all other anodes = 1, unless en = 0 or the digit
//   is leading-blanked; in either case an = all 1.
//  All outputs are registered: an, seg and dp lag FSM state/slot_cnt by one cycle.
//  Leading blank (BLANK_LEADING=1): digit i is blanked if i > index of the most
//   significant nonzero nibble of the shadow value. An all-zero value shows "0" on
//   digit 0 only. A blanked digit also forces dp = 1.
//  Handshake: load_ready = ~pending. A transfer occurs when load_valid && load_ready;
//   value/dp are copied into pending regs and pending is set (load_ready = 0 on the
//   next cycle).
//  Frame boundary: the last cycle of digit NUM_DIGITS-1's slot. On that cycle, if
//   pending = 1, pending regs are copied to shadow and pending is cleared. The new
//   value is shown from digit 0 of the next frame, so a frame never tears.
//  Simultaneous transfer and frame boundary: the capture happens, but the commit
//   waits for the next boundary. Frames therefore always show a single value.
//  load_valid while load_ready = 0 is ignored; no data is lost because the producer
//   holds it.
//  rst mid-slot: all outputs go to reset values immediately; any pending value is discarded.
//  en toggles only gate the anodes; slot/digit sequencing is unaffected.
// STRUCTURE
//  seg_pkg: glyph table (16 hex codes, active low), SEG_OFF = 7'h7F, ANODE_OFF
//   helper function, FSM state enum {BLANK, DRIVE}.
//  hex_to_seg: combinational nibble->7'b active-low glyph, instantiated once on the
//   muxed nibble.
//  Everything else (counters, FSM, pending/shadow regs, leading-zero logic) lives here.
// TESTING  (NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, BLANK_LEADING=1)
//  Reset then load 16'h1234 -> from the next frame, digit 0 shows seg=glyph(4) with
//   an=4'b1110 for 6 cycles, preceded by 2 cycles of an=4'b1111. Digits 1..3 follow
//   in order with 32-cycle frame period.
//  Load 16'h0050 -> digits 3 and 2 have an held at 4'b1111 in DRIVE; digits 1 and 0
//   show 5 and 0. Load 16'h0000 -> only digit 0 is lit, showing "0".
//  Load 16'hAAAA, then assert load_valid with 16'hBBBB while ready = 0 -> ignored;
//   after the boundary, ready = 1 and 16'hBBBB is accepted. Every frame shows all A
//   or all B.
//  Transfer exactly on the frame-boundary cycle -> the old value stays for one more
//   full frame; the new value appears from the frame after.
//  en = 0 for 20 cycles mid-frame -> an = 4'b1111 throughout; digit_idx/slot timing
//   stays unchanged when en returns.
//  Assert rst during a DRIVE with pending set -> same cycle an=4'b1111, seg=7'h7F,
//   dp=1, load_ready=1; after release the display is blank-zero ("0" on digit 0).

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants, glyph table and scan-state type for the multiplexed 7-segment scanner.
package seven_seg_scanner_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [MAX_DIGITS-1:0] anode_off();
    return '1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] anode_drive(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seven_seg_scanner_hex_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = GLYPH[nibble_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display scanner with anti-ghost blanking, leading-zero
// suppression and a frame-aligned (tear-free) value update handshake.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DIGIT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES  = 2000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp
);

  localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q;
  scan_state_e           state_q;
  logic                  pend_q;
  logic                  ready_q;
  logic [VAL_W-1:0]      pend_val_q, shad_val_q;
  logic [NUM_DIGITS-1:0] pend_dp_q, shad_dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]      seg_q;
  logic                  dp_q;

  logic             last_slot, last_digit, frame_end;
  logic [IDX_W-1:0] msnz;
  logic             blanked;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic [SEG_W-1:0] glyph_c;

  assign last_slot  = (slot_cnt_q == CNT_W'(DIGIT_CYCLES - 1));
  assign last_digit = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = last_slot && last_digit;
  assign slot_cnt_d = last_slot ? '0 : slot_cnt_q + 1'b1;

  // Current digit's nibble/dp and the index of the most significant nonzero nibble
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    msnz    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == digit_idx_q) begin
        cur_nib = shad_val_q[4*i +: 4];
        cur_dp  = shad_dp_q[i];
      end
      if (shad_val_q[4*i +: 4] != 4'h0) msnz = IDX_W'(i);
    end
  end

  assign blanked = (BLANK_LEADING != 0) && (digit_idx_q > msnz);

  seven_seg_scanner_hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nib),
    .seg_c    (glyph_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      state_q     <= BLANK;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      shad_val_q  <= '0;
      shad_dp_q   <= '0;
      an_q        <= NUM_DIGITS'(anode_off());
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      if (last_slot) digit_idx_q <= last_digit ? '0 : digit_idx_q + 1'b1;
      state_q <= (slot_cnt_d < CNT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;

      case (state_q)
        BLANK: begin
          an_q <= NUM_DIGITS'(anode_off());
          // Segments settle during the blank window before the anode turns on
          if (slot_cnt_q == '0) begin
            seg_q <= glyph_c;
            dp_q  <= blanked | ~cur_dp;
          end
        end
        DRIVE: begin
          an_q <= (en && !blanked) ? NUM_DIGITS'(anode_drive(3'(digit_idx_q)))
                                   : NUM_DIGITS'(anode_off());
        end
        default: an_q <= NUM_DIGITS'(anode_off());
      endcase

      // Capture into pending; commit to shadow only on the last cycle of a frame
      if (load_valid && ready_q) begin
        pend_q     <= 1'b1;
        ready_q    <= 1'b0;
        pend_val_q <= load_value;
        pend_dp_q  <= load_dp;
      end else if (frame_end && pend_q) begin
        pend_q     <= 1'b0;
        ready_q    <= 1'b1;
        shad_val_q <= pend_val_q;
        shad_dp_q  <= pend_dp_q;
      end
    end
  end

  assign load_ready = ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_seg_scanner;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] GA = 7'h08;
  localparam logic [6:0] GB = 7'h03;
  localparam logic [6:0] GC = 7'h46;
  localparam logic [6:0] GD = 7'h21;
  localparam logic [6:0] GE = 7'h06;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [6:0] exp_g [4];
  logic [3:0] exp_lit;
  logic [3:0] exp_dpn;

  seven_seg_scanner #(
    .NUM_DIGITS    (4),
    .DIGIT_CYCLES  (8),
    .BLANK_CYCLES  (2),
    .BLANK_LEADING (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, req);
    end
  endtask

  task automatic set_exp(input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                         input logic [6:0] g0, input logic [3:0] lit, input logic [3:0] dpn);
    exp_g[3] = g3;
    exp_g[2] = g2;
    exp_g[1] = g1;
    exp_g[0] = g0;
    exp_lit  = lit;
    exp_dpn  = dpn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Outputs seen after tick n reflect frame position (n-1) mod 32
  task automatic check_ticks(input int n);
    int p, d, s;
    logic [3:0] ea;
    for (int i = 0; i < n; i++) begin
      tick();
      p  = (cyc - 1) % 32;
      d  = p / 8;
      s  = p % 8;
      ea = 4'hF;
      if (s >= 2 && exp_lit[d] && en) ea[d] = 1'b0;
      chk("an",  16'(an),  16'(ea));
      chk("seg", 16'(seg), 16'(exp_g[d]));
      chk("dp",  16'(dp),  16'(exp_dpn[d]));
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dpv);
    load_value = v;
    load_dp    = dpv;
    load_valid = 1'b1;
    check_ticks(1);
    load_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an",    16'(an),         16'hF);
    chk("rst_seg",   16'(seg),        16'h7F);
    chk("rst_dp",    16'(dp),         16'h1);
    chk("rst_ready", 16'(load_ready), 16'h1);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    load_valid = 1'b0;
    load_value = 16'h0;
    load_dp    = 4'h0;
    #12;
    chk_reset_outputs();
    rst = 1'b0;
    cyc = 0;

    // Power-up value is zero: only digit 0 lit with "0"
    set_exp(G0, G0, G0, G0, 4'b0001, 4'b1111);
    check_ticks(32);

    // 1234: accepted mid-frame, shown from the next frame
    load(16'h1234, 4'b0000);
    chk("ready_after_load", 16'(load_ready), 16'h0);
    check_ticks(31);
    chk("ready_after_commit", 16'(load_ready), 16'h1);
    set_exp(G1, G2, G3, G4, 4'b1111, 4'b1111);
    check_ticks(32);

    // 0050 with dp on digits 1 and 2: digit 2 is leading-blanked, so its dp stays off
    load(16'h0050, 4'b0110);
    check_ticks(31);
    set_exp(G0, G0, G5, G0, 4'b0011, 4'b1101);
    check_ticks(32);

    load(16'h0000, 4'b0000);
    check_ticks(31);
    set_exp(G0, G0, G0, G0, 4'b0001, 4'b1111);
    check_ticks(32);

    // AAAA accepted; BBBB held while not ready is ignored until the boundary
    load(16'hAAAA, 4'b0000);
    load_value = 16'hBBBB;
    load_valid = 1'b1;
    check_ticks(31);
    chk("ready_reopens", 16'(load_ready), 16'h1);
    set_exp(GA, GA, GA, GA, 4'b1111, 4'b1111);
    check_ticks(1);
    load_valid = 1'b0;
    chk("ready_bbbb_taken", 16'(load_ready), 16'h0);
    check_ticks(31);
    set_exp(GB, GB, GB, GB, 4'b1111, 4'b1111);
    check_ticks(32);

    // Transfer on the frame-boundary cycle: old value persists one more frame
    check_ticks(31);
    load(16'hC0DE, 4'b0000);
    chk("ready_boundary_load", 16'(load_ready), 16'h0);
    check_ticks(32);
    chk("ready_boundary_commit", 16'(load_ready), 16'h1);
    set_exp(GC, G0, GD, GE, 4'b1111, 4'b1111);

    // en low mid-frame only gates anodes
    check_ticks(10);
    en = 1'b0;
    check_ticks(20);
    en = 1'b1;
    check_ticks(2);
    check_ticks(8);

    // Async reset during DRIVE with a pending value
    load(16'h5555, 4'b1111);
    chk("ready_pending", 16'(load_ready), 16'h0);
    check_ticks(3);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    #2;
    rst = 1'b0;
    cyc = 0;
    set_exp(G0, G0, G0, G0, 4'b0001, 4'b1111);
    check_ticks(32);
    check_ticks(32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
